// File: rtl/out_port_display_pkg.sv
// Shared definitions for the out_port0 decimal display.
//   - Active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - Converter FSM state encoding
//   - BCD digit count needed to hold a binary word of a given width
package out_port_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_UPD  = 2'd2
    } state_e;

    // Every 3 binary bits need at most one decimal digit (2^3 < 10).
    function automatic int unsigned bcd_digits(input int unsigned width);
        return (width + 2) / 3;
    endfunction

endpackage

// File: rtl/out_port_display_seg7_encode.sv
// Combinational BCD to active-low 7-segment decoder.
//   bcd_i   : BCD digit (codes 10-15 display blank)
//   blank_i : force the digit dark
//   seg_o   : segments {g,f,e,d,c,b,a}, active-low
module seg7_encode
    import out_port_display_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/out_port_display.sv
// Shows the CPU out_port0 word as an unsigned decimal number on NUM_DIGITS
// active-low 7-segment displays. Binary-to-BCD is sequential double-dabble,
// one bit per clock, so the display follows the input DATA_WIDTH+2 cycles later.
//   clock     : processor clock
//   resetn    : synchronous active-low reset
//   out_port0 : value to display (unsigned)
//   hex_out   : digit k at [7k+6:7k], {g,f,e,d,c,b,a}, active-low
//   busy      : conversion in flight
//   overflow  : value has nonzero decimal digits beyond NUM_DIGITS
// NUM_DIGITS must not exceed the BCD digit count of DATA_WIDTH.
module out_port_display
    import out_port_display_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic [DATA_WIDTH-1:0]   out_port0,
    output logic [7*NUM_DIGITS-1:0] hex_out,
    output logic                    busy,
    output logic                    overflow
);

    localparam int unsigned BCD_DIGITS = bcd_digits(DATA_WIDTH);
    localparam int unsigned BCD_W      = 4 * BCD_DIGITS;
    localparam int unsigned CNT_W      = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    // Display of the value 0: digit 0 always lit, the rest blank or zero.
    function automatic logic [7*NUM_DIGITS-1:0] reset_pattern();
        logic [7*NUM_DIGITS-1:0] pat;
        pat = '0;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            pat[7*k+:7] = (k == 0 || BLANK_LZ == 0) ? SEG_0 : SEG_BLANK;
        end
        return pat;
    endfunction

    localparam logic [7*NUM_DIGITS-1:0] HEX_RST = reset_pattern();

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   in_q;
    logic [DATA_WIDTH-1:0]   shown_q;
    logic [DATA_WIDTH-1:0]   cap_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic                    busy_q;
    logic                    ovf_q;

    logic [BCD_W-1:0]        bcd_adj;
    logic                    ovf_w;
    logic [NUM_DIGITS-1:0]   blank_w;
    logic [7*NUM_DIGITS-1:0] seg_w;

    // Double-dabble correction: 4-bit add, 5..9 become 8..12, no carry out.
    always_comb begin
        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i+:4] >= 4'd5) begin
                bcd_adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
            end
        end
    end

    always_comb begin
        ovf_w = 1'b0;
        for (int unsigned i = NUM_DIGITS; i < BCD_DIGITS; i++) begin
            ovf_w = ovf_w | (|bcd_q[4*i+:4]);
        end
    end

    // Leading-zero blanking walks down from the top digit and stops at the
    // first nonzero one; overflow shows every digit so the truncation is visible.
    always_comb begin
        logic lead;
        lead    = (BLANK_LZ != 0) && !ovf_w;
        blank_w = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 1; k--) begin
            if (lead && bcd_q[4*k+:4] == 4'd0) begin
                blank_w[k] = 1'b1;
            end else begin
                lead = 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        seg7_encode u_seg7_encode (
            .bcd_i   (bcd_q[4*k+:4]),
            .blank_i (blank_w[k]),
            .seg_o   (seg_w[7*k+:7])
        );
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            shown_q <= '0;
            cap_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hex_q   <= HEX_RST;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            in_q <= out_port0;
            case (state_q)
                ST_IDLE: begin
                    if (in_q != shown_q) begin
                        shift_q <= in_q;
                        cap_q   <= in_q;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_q, shift_q} <= {bcd_adj, shift_q} << 1;
                    cnt_q            <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    hex_q   <= seg_w;
                    ovf_q   <= ovf_w;
                    shown_q <= cap_q;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign hex_out  = hex_q;
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_out_port_display.sv
module tb_out_port_display;

    logic        clock;
    logic        resetn;
    logic [31:0] out_port0;
    logic [41:0] hex_out;
    logic        busy;
    logic        overflow;

    int unsigned checks;
    int unsigned errors;
    int unsigned cyc;
    logic        rst_at_edge;
    logic        busy_prev;
    int unsigned rise_cyc;

    typedef struct {
        logic [41:0] hex;
        logic        ovf;
        int unsigned due;
    } exp_t;

    exp_t sb_q[$];

    out_port_display #(
        .DATA_WIDTH (32),
        .NUM_DIGITS (6),
        .BLANK_LZ   (1)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .out_port0 (out_port0),
        .hex_out   (hex_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc         <= cyc + 1;
        rst_at_edge <= ~resetn;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0:       return 7'b1000000;
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    // Returns {overflow, hex_out} for a displayed value.
    function automatic logic [42:0] model(input logic [31:0] v);
        longint unsigned x;
        int              d[6];
        logic            ovf;
        logic            lead;
        logic [41:0]     h;
        x = 64'(v);
        for (int k = 0; k < 6; k++) begin
            d[k] = int'(x % 10);
            x    = x / 10;
        end
        ovf  = (x != 0);
        lead = 1'b1;
        h    = '0;
        for (int k = 5; k >= 0; k--) begin
            if (lead && k > 0 && !ovf && d[k] == 0) begin
                h[7*k+:7] = 7'b1111111;
            end else begin
                lead      = 1'b0;
                h[7*k+:7] = seg(d[k]);
            end
        end
        return {ovf, h};
    endfunction

    task automatic push_exp(input logic [31:0] v, input int unsigned due);
        exp_t        e;
        logic [42:0] m;
        m     = model(v);
        e.ovf = m[42];
        e.hex = m[41:0];
        e.due = due;
        sb_q.push_back(e);
    endtask

    // Called at a negedge; captured at the next edge t, displayed at t+34.
    task automatic put(input logic [31:0] v);
        out_port0 = v;
        push_exp(v, cyc + 35);
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clock);
            if (sb_q.size() == 0 && !busy) done = 1'b1;
        end
        check("wait_idle_timeout", done, 1'b1);
    endtask

    // Scoreboard: each completed conversion pops one expectation.
    always @(negedge clock) begin
        exp_t e;
        if (!rst_at_edge) begin
            if (!busy_prev && busy) rise_cyc <= cyc;
            if (busy_prev && !busy) begin
                check("busy_len", cyc - rise_cyc, 33);
                check("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("hex", hex_out, e.hex);
                    check("ovf", overflow, e.ovf);
                    check("latency", cyc, e.due);
                end
            end
        end
        busy_prev <= busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [41:0] hex_rst;
        logic        saw_busy;
        logic [42:0] m7;
        int unsigned n;

        hex_rst   = {{5{7'b1111111}}, 7'b1000000};
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        busy_prev = 1'b0;
        rise_cyc  = 0;
        resetn    = 1'b0;
        out_port0 = 32'd0;

        repeat (5) @(negedge clock);
        check("rst_hex", hex_out, hex_rst);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);

        resetn   = 1'b1;
        saw_busy = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (busy) saw_busy = 1'b1;
        end
        check("idle0_busy", saw_busy, 1'b0);
        check("idle0_hex", hex_out, hex_rst);

        put(32'd1234);
        wait_idle();

        put(32'd999999);
        wait_idle();
        put(32'd1000000);
        wait_idle();

        put(32'hFFFF_FFFF);
        wait_idle();

        // Second value arrives mid-conversion and is picked up next IDLE.
        n = cyc;
        put(32'd5);
        repeat (3) @(negedge clock);
        out_port0 = 32'd7;
        push_exp(32'd7, n + 69);
        while (cyc < n + 35) @(negedge clock);
        check("gap_busy_low", busy, 1'b0);
        @(negedge clock);
        check("gap_busy_high", busy, 1'b1);
        wait_idle();
        check("final_digit0", hex_out[6:0], 7'b1111000);

        // Unchanged value never restarts the converter.
        m7       = model(32'd7);
        saw_busy = 1'b0;
        out_port0 = 32'd7;
        repeat (40) begin
            @(negedge clock);
            if (busy) saw_busy = 1'b1;
        end
        check("hold_busy", saw_busy, 1'b0);
        check("hold_hex", hex_out, m7[41:0]);

        // Reset at CONV cycle 10 discards the partial conversion.
        n = cyc;
        put(32'd4321);
        repeat (10) @(negedge clock);
        resetn = 1'b0;
        sb_q.delete();
        @(negedge clock);
        check("midrst_hex", hex_out, hex_rst);
        check("midrst_busy", busy, 1'b0);
        check("midrst_ovf", overflow, 1'b0);
        resetn = 1'b1;
        push_exp(32'd4321, cyc + 35);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
